// File: rtl/bcd_xs3_pkg.sv
// +----------------------------------------------------------------------+
// | bcd_xs3_pkg: shared constants and types for the BCD to XS3 sequencer  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package bcd_xs3_pkg;

    localparam logic [3:0] XS3_OFFSET  = 4'd3;
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] XS3_INVALID = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [3:0] digit_t;

endpackage

`default_nettype wire

// File: rtl/bcd_xs3_digit.sv
// +----------------------------------------------------------------------+
// | bcd_xs3_digit: combinational single-digit BCD to excess-3 converter   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_xs3_digit
    import bcd_xs3_pkg::*;
(
    input  digit_t digit,
    output digit_t xs3,
    output logic   err
);

    // Non-BCD codes map to a fixed marker so the result is always defined.
    assign err = (digit > BCD_MAX);
    assign xs3 = err ? XS3_INVALID : digit_t'(digit + XS3_OFFSET);

endmodule

`default_nettype wire

// File: rtl/bcd_xs3_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | bcd_xs3_seq_ctrl: converts a packed BCD word to excess-3, one digit   |
// | per clock, through one shared converter. Revision: 1.0                |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_xs3_seq_ctrl
    import bcd_xs3_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_xs3,
    output logic [DIGITS-1:0]     out_err,
    output logic                  out_any_err,
    output logic                  busy
);

    localparam int              IDXW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DIGITS - 1);

    state_t                r_state;
    logic [IDXW-1:0]       r_idx;
    logic [4*DIGITS-1:0]   r_word;
    logic [4*DIGITS-1:0]   r_xs3;
    logic [DIGITS-1:0]     r_err;
    logic                  r_any_err;

    digit_t                w_digit;
    digit_t                w_xs3;
    logic                  w_err;

    // The captured word shifts right, so the current digit is always the low nibble.
    assign w_digit = r_word[3:0];

    bcd_xs3_digit u_digit (
        .digit (w_digit),
        .xs3   (w_xs3),
        .err   (w_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_word    <= '0;
            r_xs3     <= '0;
            r_err     <= '0;
            r_any_err <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_word    <= in_bcd;
                        r_xs3     <= '0;
                        r_err     <= '0;
                        r_any_err <= 1'b0;
                        r_idx     <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= CONV;
                    end
                end
                CONV: begin
                    r_word    <= r_word >> 4;
                    r_any_err <= r_any_err | w_err;
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_idx == IDXW'(i)) begin
                            r_xs3[4*i +: 4] <= w_xs3;
                            r_err[i]        <= w_err;
                        end
                    end
                    if (r_idx == IDX_LAST) begin
                        r_idx     <= '0;
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign out_xs3     = r_xs3;
    assign out_err     = r_err;
    assign out_any_err = r_any_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// Self-checking bench for bcd_xs3_seq_ctrl with a digit-arithmetic reference model.
`default_nettype none

module tb_bcd_xs3_seq_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b0;
    logic [W-1:0]      in_bcd    = '0;
    logic              in_ready;
    logic              out_valid;
    logic [W-1:0]      out_xs3;
    logic [DIGITS-1:0] out_err;
    logic              out_any_err;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_xs3_seq_ctrl #(.DIGITS(DIGITS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bcd      (in_bcd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_xs3     (out_xs3),
        .out_err     (out_err),
        .out_any_err (out_any_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference: each decimal digit plus three; non-decimal digits give F and flag.
    function automatic void model(input logic [W-1:0] w, output logic [W-1:0] x,
                                  output logic [DIGITS-1:0] e);
        int d;
        x = '0;
        e = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'((w >> (4 * i)) & W'(15));
            if (d <= 9) x = x | (W'(d + 3) << (4 * i));
            else begin
                x = x | (W'(15) << (4 * i));
                e[i] = 1'b1;
            end
        end
    endfunction

    // Sends one word and collects its result; caller sits at a negedge.
    task automatic do_word(input logic [W-1:0] word, input int hold,
                           output logic [W-1:0] gx, output logic [DIGITS-1:0] ge,
                           output logic ga, output int lat, output bit ok);
        int n = 0;
        ok = 1'b1; gx = '0; ge = '0; ga = 1'b0; lat = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin ok = 1'b0; return; end
        in_valid = 1'b1; in_bcd = word;
        @(negedge clk);
        in_valid = 1'b0; in_bcd = W'($urandom);
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        if (!out_valid) begin ok = 1'b0; return; end
        gx = out_xs3; ge = out_err; ga = out_any_err;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, busy, out_xs3, out_err, out_any_err} !== {3'b100, W'(0), DIGITS'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b vld=%b busy=%b xs3=%h err=%b any=%b, expected 1 0 0 0000 0000 0",
                     in_ready, out_valid, busy, out_xs3, out_err, out_any_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_word(input string name, input logic [W-1:0] word, input int hold);
        logic [W-1:0] gx, ex; logic [DIGITS-1:0] ge, ee; logic ga; int lat; bit ok;
        model(word, ex, ee);
        do_word(word, hold, gx, ge, ga, lat, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: word %h got no handshake, expected a result", name, word);
            return;
        end
        n_checks++;
        if (lat !== DIGITS) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, DIGITS);
        end
        n_checks++;
        if ({gx, ge, ga} !== {ex, ee, |ee}) begin
            n_fail++;
            $display("FAIL %s_result: word %h got xs3=%h err=%b any=%b expected xs3=%h err=%b any=%b",
                     name, word, gx, ge, ga, ex, ee, |ee);
        end
    endtask

    task automatic test_single();
        check_word("single_1295", 16'h1295, 0);
    endtask

    task automatic test_errors();
        check_word("err_9a01", 16'h9A01, 1);
        check_word("err_ffff", 16'hFFFF, 0);
    endtask

    task automatic test_back_to_back();
        int seen = 0, acc = 0, overlap = 0;
        int vcyc[2];
        logic [W-1:0] got[2];
        vcyc[0] = 0; vcyc[1] = 0; got[0] = '0; got[1] = '0;
        in_bcd = 16'h0000; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 40 && seen < 2; c++) begin
            if (busy && in_ready) overlap++;
            if (out_valid) begin vcyc[seen] = c; got[seen] = out_xs3; seen++; end
            if (in_ready && in_valid) acc++;
            @(posedge clk); #1;
            if (acc == 1) in_bcd = 16'h9999;
            else if (acc >= 2) in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (seen !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results expected 2", seen);
        end
        n_checks++;
        if (vcyc[1] - vcyc[0] !== DIGITS + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles expected %0d", vcyc[1] - vcyc[0], DIGITS + 2);
        end
        n_checks++;
        if ({got[0], got[1]} !== {16'h3333, 16'hCCCC}) begin
            n_fail++;
            $display("FAIL b2b_results: got %h %h expected 3333 cccc", got[0], got[1]);
        end
        n_checks++;
        if (overlap !== 0) begin
            n_fail++;
            $display("FAIL b2b_in_ready_busy: got %0d cycles with in_ready during busy expected 0", overlap);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ex; logic [DIGITS-1:0] ee;
        int n = 0, bad = 0;
        model(16'h3807, ex, ee);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        in_valid = 1'b1; in_bcd = 16'h3807;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        n_checks++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL bp_timeout: got out_valid=0 expected 1");
            return;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_bcd   = W'($urandom);
            @(negedge clk);
            if (!(out_valid === 1'b1 && out_xs3 === ex && out_err === ee && in_ready === 1'b0)) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d unstable cycles (last xs3=%h err=%b) expected 0 with xs3=%h err=%b",
                     bad, out_xs3, out_err, ex, ee);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL bp_release: got vld/rdy/busy=%b expected 010", {out_valid, in_ready, busy});
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_idle: got vld/busy=%b expected 00", {out_valid, busy});
        end
    endtask

    task automatic test_mid_reset();
        int n = 0, seen = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        in_valid = 1'b1; in_bcd = 16'h4567;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_busy: got %b expected 1", busy);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, out_xs3, out_err, out_any_err} !== {3'b100, W'(0), DIGITS'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_values: got rdy=%b vld=%b busy=%b xs3=%h err=%b any=%b expected 1 0 0 0000 0000 0",
                     in_ready, out_valid, busy, out_xs3, out_err, out_any_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_no_result: got %0d valid cycles expected 0", seen);
        end
        check_word("after_reset_0008", 16'h0008, 0);
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        for (int k = 0; k < 20; k++) begin
            w = '0;
            for (int i = 0; i < DIGITS; i++)
                w = w | (W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9)) << (4 * i));
            check_word("random", w, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_errors();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/bcd_xs3_seq_ctrl.md
# bcd_xs3_seq_ctrl

Sequencing controller that converts a packed multi-digit BCD word to excess-3, one digit per clock, through a single shared per-digit converter. It sits between a BCD producer and an excess-3 consumer. Both sides use valid/ready handshakes. Each digit is checked for validity and flagged individually, so downstream logic can reject malformed words without re-decoding them.

## Interface
- DIGITS, 4: number of BCD digits per word (1..8).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has a word on in_bcd.
- in_ready  out  1  controller can accept a word (IDLE only).
- in_bcd  in  4*DIGITS  packed BCD; digit i = in_bcd[4i+3:4i], digit 0 least significant.
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer accepts result.
- out_xs3  out  4*DIGITS  packed excess-3 result, same digit order.
- out_err  out  DIGITS  bit i set when input digit i > 9.
- out_any_err  out  1  OR-reduction of out_err.
- busy  out  1  high in CONV or DONE.

## Operation
- FSM states: IDLE, CONV, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready at an edge: capture in_bcd into the shift register, clear the result and error registers, set digit index to 0, go to CONV.
- CONV:
  - in_ready=0.
  - Each cycle, digit[idx] of the captured word feeds the converter.
  - The 4-bit result goes to out_xs3 slot idx; the error bit goes to out_err[idx].
  - idx increments each cycle.
  - When idx==DIGITS-1 is processed, go to DONE.
- Conversion per digit:
  - 0..9 → digit+3, computed 4-bit unsigned with no carry out (max 12).
  - 10..15 → result 4'hF and error bit set. The output is never X.
- DONE:
  - out_valid=1. out_xs3, out_err and out_any_err are held stable until out_valid&out_ready.
  - On that handshake, go to IDLE.
  - out_ready is ignored in all other states.
- in_valid is ignored outside IDLE. The captured word is unaffected by in_bcd changes after acceptance.
- Reset values:
  - in_ready=1, out_valid=0, busy=0.
  - out_xs3=0, out_err=0, out_any_err=0.
  - idx=0.
- Reset mid-CONV or mid-DONE: the in-flight word is dropped silently, all outputs go to reset values asynchronously, and no partial result is ever presented.
- in_valid and out_ready high in the same cycle: only one applies, determined by state. There is no back-to-back overlap (IDLE and DONE are exclusive).

## Timing
- Acceptance edge T0 → CONV occupies edges T0+1..T0+DIGITS.
- out_valid is high in the cycle after edge T0+DIGITS. Latency is DIGITS cycles.
- With out_ready held high, the handshake is at edge T0+DIGITS+1 and in_ready rises in the following cycle.
- Minimum word period: DIGITS+2 cycles.
- All outputs are registered. No combinational path from in_valid/out_ready to in_ready/out_valid.
- out_any_err is valid in the same cycle as out_valid.

## Structure
- Package bcd_xs3_pkg contains:
  - XS3_OFFSET=4'd3, BCD_MAX=4'd9, XS3_INVALID=4'hF.
  - The FSM state typedef (IDLE, CONV, DONE).
  - A 4-bit digit typedef.
- Sub-module bcd_xs3_digit:
  - Combinational, one instance, shared across digits.
  - Inputs: 4-bit digit. Outputs: 4-bit excess-3, 1-bit err.
- Top: FSM, index counter of width clog2(DIGITS) with minimum 1, captured-word register, result/error registers.

## Test plan
All scenarios use DIGITS=4.
- Reset release, in_bcd=16'h1295, in_valid pulse → out_valid 4 cycles after acceptance, out_xs3=16'h45C8, out_err=4'b0000.
- in_bcd=16'h0000 then 16'h9999, back-to-back producer, out_ready=1 → results 16'h3333 then 16'hCCCC, words spaced 6 cycles apart. in_ready is low throughout CONV and DONE.
- in_bcd=16'h9A01 → out_xs3=16'hCF34, out_err=4'b0100, out_any_err=1. in_bcd=16'hFFFF → out_xs3=16'hFFFF, out_err=4'b1111.
- out_ready=0 for 10 cycles in DONE → out_valid stays 1 and out_xs3/out_err are unchanged. in_valid toggling during this time is ignored. Raising out_ready gives one handshake, then IDLE.
- rst_n pulsed low during the 2nd CONV cycle of 16'h4567 → outputs immediately at reset values and out_valid never asserts for that word. The next word 16'h0008 gives 16'h333B.
